// File: rtl/mem_stage_lsu_if.sv
// Data-memory port of the memory-access stage: req/gnt/rvalid handshake.
// master = LSU side, slave = memory side.
interface mem_stage_lsu_if;
  logic        dmem_req_o;
  logic        dmem_we_o;
  logic [63:0] dmem_addr_o;
  logic [63:0] dmem_wdata_o;
  logic [7:0]  dmem_wstrb_o;
  logic        dmem_gnt_i;
  logic        dmem_rvalid_i;
  logic [63:0] dmem_rdata_i;

  modport master (
    output dmem_req_o, dmem_we_o, dmem_addr_o, dmem_wdata_o, dmem_wstrb_o,
    input  dmem_gnt_i, dmem_rvalid_i, dmem_rdata_i
  );

  modport slave (
    input  dmem_req_o, dmem_we_o, dmem_addr_o, dmem_wdata_o, dmem_wstrb_o,
    output dmem_gnt_i, dmem_rvalid_i, dmem_rdata_i
  );
endinterface

// File: rtl/mem_stage_lsu.sv
// rv64 memory-access stage: issues loads/stores, stalls the front end while busy.
// Define LSU_MISALIGN_TRAP_EN to flag size-misaligned accesses instead of issuing them.
module mem_stage_lsu (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_i,
  input  logic [63:0] alu_result_i,
  input  logic [63:0] store_data_i,
  input  logic [2:0]  funct3_i,
  input  logic        mem_read_i,
  input  logic        mem_write_i,
  input  logic [4:0]  rd_addr_i,
  input  logic        reg_write_i,
  input  logic        mem_to_reg_i,
  output logic [63:0] alu_result_o,
  output logic [63:0] mem_data_o,
  output logic [4:0]  rd_addr_o,
  output logic        reg_write_o,
  output logic        mem_to_reg_o,
  output logic        stall_o,
  mem_stage_lsu_if.master dmem
`ifdef LSU_MISALIGN_TRAP_EN
  ,
  output logic        misalign_o
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

  state_t      r_state;
  logic        r_req;
  logic        r_we;
  logic [63:0] r_addr;
  logic [2:0]  r_funct3;
  logic [4:0]  r_rd;
  logic        r_reg_write;
  logic        r_mem_to_reg;
  logic [63:0] r_wdata;
  logic [7:0]  r_wstrb;
  logic [63:0] r_load_data;

  logic        w_mem_op;
  logic        w_misaligned;
  logic        w_issue;
  logic [2:0]  w_offset;
  logic [5:0]  w_shamt;
  logic [7:0]  w_size_mask;
  logic [7:0]  w_wstrb;
  logic [63:0] w_wdata;
  logic [63:0] w_lane;
  logic [63:0] w_load_ext;

  assign w_mem_op = valid_i & (mem_read_i | mem_write_i);
  assign w_offset = alu_result_i[2:0];
  assign w_shamt  = {w_offset, 3'b000};

  always_comb begin
    w_size_mask = 8'hFF;
    case (funct3_i[1:0])
      2'b00:   w_size_mask = 8'h01;
      2'b01:   w_size_mask = 8'h03;
      2'b10:   w_size_mask = 8'h0F;
      default: w_size_mask = 8'hFF;
    endcase
  end

  // Bytes shifted past lane 7 fall off: cross-doubleword stores are truncated.
  assign w_wstrb = w_size_mask << w_offset;
  assign w_wdata = store_data_i << w_shamt;

`ifdef LSU_MISALIGN_TRAP_EN
  always_comb begin
    w_misaligned = 1'b0;
    case (funct3_i[1:0])
      2'b00:   w_misaligned = 1'b0;
      2'b01:   w_misaligned = alu_result_i[0];
      2'b10:   w_misaligned = |alu_result_i[1:0];
      default: w_misaligned = |alu_result_i[2:0];
    endcase
  end
  assign misalign_o = (r_state == S_IDLE) & w_mem_op & w_misaligned;
`else
  assign w_misaligned = 1'b0;
`endif

  assign w_issue = (r_state == S_IDLE) & w_mem_op & ~w_misaligned;

  // Zero-fill from the top means bytes beyond the doubleword read as 0.
  assign w_lane = dmem.dmem_rdata_i >> {r_addr[2:0], 3'b000};

  always_comb begin
    w_load_ext = w_lane;
    case (r_funct3)
      3'b000:  w_load_ext = {{56{w_lane[7]}},  w_lane[7:0]};
      3'b001:  w_load_ext = {{48{w_lane[15]}}, w_lane[15:0]};
      3'b010:  w_load_ext = {{32{w_lane[31]}}, w_lane[31:0]};
      3'b100:  w_load_ext = {56'd0, w_lane[7:0]};
      3'b101:  w_load_ext = {48'd0, w_lane[15:0]};
      3'b110:  w_load_ext = {32'd0, w_lane[31:0]};
      default: w_load_ext = w_lane;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_req        <= 1'b0;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_funct3     <= '0;
      r_rd         <= '0;
      r_reg_write  <= 1'b0;
      r_mem_to_reg <= 1'b0;
      r_wdata      <= '0;
      r_wstrb      <= '0;
      r_load_data  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_issue) begin
            r_state      <= S_REQ;
            r_req        <= 1'b1;
            r_we         <= mem_write_i;
            r_addr       <= alu_result_i;
            r_funct3     <= funct3_i;
            r_rd         <= rd_addr_i;
            r_reg_write  <= reg_write_i;
            r_mem_to_reg <= mem_to_reg_i;
            r_wdata      <= mem_write_i ? w_wdata : 64'd0;
            r_wstrb      <= mem_write_i ? w_wstrb : 8'd0;
            r_load_data  <= '0;
          end
        end
        S_REQ: begin
          if (dmem.dmem_gnt_i) begin
            r_req   <= 1'b0;
            r_state <= r_we ? S_DONE : S_WAIT;
          end
        end
        S_WAIT: begin
          if (dmem.dmem_rvalid_i) begin
            r_load_data <= w_load_ext;
            r_state     <= S_DONE;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign dmem.dmem_req_o   = r_req;
  assign dmem.dmem_we_o    = r_req & r_we;
  assign dmem.dmem_addr_o  = r_req ? {r_addr[63:3], 3'b000} : 64'd0;
  assign dmem.dmem_wdata_o = r_req ? r_wdata : 64'd0;
  assign dmem.dmem_wstrb_o = r_req ? r_wstrb : 8'd0;

  always_comb begin
    alu_result_o = alu_result_i;
    mem_data_o   = '0;
    rd_addr_o    = rd_addr_i;
    reg_write_o  = reg_write_i;
    mem_to_reg_o = mem_to_reg_i;
    stall_o      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_mem_op) begin
          reg_write_o = 1'b0;
          if (!w_misaligned) begin
            stall_o      = 1'b1;
            rd_addr_o    = '0;
            mem_to_reg_o = 1'b0;
          end
        end
      end
      S_REQ, S_WAIT: begin
        alu_result_o = r_addr;
        stall_o      = 1'b1;
        rd_addr_o    = '0;
        reg_write_o  = 1'b0;
        mem_to_reg_o = 1'b0;
      end
      default: begin
        alu_result_o = r_addr;
        mem_data_o   = r_load_data;
        rd_addr_o    = r_rd;
        reg_write_o  = r_reg_write;
        mem_to_reg_o = r_mem_to_reg;
      end
    endcase
  end

endmodule
